// File: rtl/spart_rx_if.sv
// rtl/spart_rx_if.sv - serial receive line, oversample tick and receive-buffer status bundle
interface spart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_enable;
    logic                 rxd;
    logic                 rd_data;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rda;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_enable,
        output rxd,
        output rd_data,
        input  rx_data,
        input  rda,
        input  frame_err,
        input  overrun
    );

    modport slave (
        input  rx_enable,
        input  rxd,
        input  rd_data,
        output rx_data,
        output rda,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - 8N1 serial receiver with mid-bit sampling, framing error and overrun status
module spart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      rst,
    spart_rx_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK_WAIT
    } state_t;

    state_t               state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rda;
    logic                 frame_err;
    logic                 overrun;
    logic                 rxd_m;
    logic                 rxd_s;

    assign bus.rx_data   = rx_data;
    assign bus.rda       = rda;
    assign bus.frame_err = frame_err;
    assign bus.overrun   = overrun;

    // Flops reset to the idle (high) line level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= bus.rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rda       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (bus.rd_data) begin
                rda       <= 1'b0;
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.rx_enable && !rxd_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end

                START: begin
                    if (bus.rx_enable) begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= rxd_s ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (bus.rx_enable) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= '0;
                            shift    <= {rxd_s, shift[DATA_BITS-1:1]};
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                state <= STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                STOP: begin
                    if (bus.rx_enable) begin
                        if (tick_cnt == FULL_LAST) begin
                            // Completion overrides a same-cycle read clear.
                            tick_cnt  <= '0;
                            rx_data   <= shift;
                            rda       <= 1'b1;
                            frame_err <= !rxd_s;
                            if (bus.rd_data) begin
                                overrun <= 1'b0;
                            end else if (rda) begin
                                overrun <= 1'b1;
                            end
                            state <= rxd_s ? IDLE : BRK_WAIT;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                BRK_WAIT: begin
                    if (rxd_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spart_rx.sv
// tb/tb_spart_rx.sv - randomized and directed bench for spart_rx against a tick-offset receive model
module tb_spart_rx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rxd = 1'b1;
    logic rx_enable = 1'b0;
    logic rd_data = 1'b0;
    int   div = 1;
    bit   rnd_rd = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    spart_rx_if #(.DATA_BITS(8)) bus ();
    assign bus.rxd       = rxd;
    assign bus.rx_enable = rx_enable;
    assign bus.rd_data   = rd_data;

    spart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (cnt >= div - 1) begin
                rx_enable = 1'b1;
                cnt = 0;
            end else begin
                rx_enable = 1'b0;
                cnt++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rnd_rd) rd_data = ($urandom_range(0, 39) == 0);
        end
    end

    // Model: a frame is a set of sample points at fixed tick offsets from the start tick.
    logic [7:0] m_data, m_acc;
    logic       m_rda, m_fe, m_ov;
    bit         m_busy, m_brk, m_done_now;
    int         m_ofs, m_done, m_k;
    logic       m_h0, m_h1, m_rs;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_data = 8'h00; m_acc = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
            m_busy = 1'b0; m_brk = 1'b0; m_ofs = 0; m_h0 = 1'b1; m_h1 = 1'b1;
        end else begin
            m_rs = m_h1;
            m_h1 = m_h0;
            m_h0 = rxd;
            m_done_now = 1'b0;
            if (m_brk) begin
                if (m_rs) m_brk = 1'b0;
            end else if (rx_enable) begin
                if (!m_busy) begin
                    if (!m_rs) begin
                        m_busy = 1'b1;
                        m_ofs = 0;
                    end
                end else begin
                    m_ofs++;
                    if (m_ofs == 8) begin
                        if (m_rs) m_busy = 1'b0;
                    end else if (m_ofs > 8 && (m_ofs - 8) % 16 == 0) begin
                        m_k = (m_ofs - 8) / 16;
                        if (m_k <= 8) begin
                            m_acc[m_k-1] = m_rs;
                        end else begin
                            m_ov = rd_data ? 1'b0 : (m_rda ? 1'b1 : m_ov);
                            m_data = m_acc;
                            m_rda = 1'b1;
                            m_fe = !m_rs;
                            m_brk = !m_rs;
                            m_busy = 1'b0;
                            m_done++;
                            m_done_now = 1'b1;
                        end
                    end
                end
            end
            if (!m_done_now && rd_data) begin
                m_rda = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            total_cnt++;
            if (bus.rx_data === m_data && bus.rda === m_rda && bus.frame_err === m_fe && bus.overrun === m_ov)
                pass_cnt++;
            else
                $display("FAIL cycle_cmp t=%0t got data=%h rda=%b fe=%b ov=%b expected data=%h rda=%b fe=%b ov=%b",
                         $time, bus.rx_data, bus.rda, bus.frame_err, bus.overrun, m_data, m_rda, m_fe, m_ov);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (16 * div) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_rd();
        rd_data = 1'b1;
        @(negedge clk);
        rd_data = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, d0;
        bit found;
        logic [7:0] rb;
        logic st;

        repeat (3) @(negedge clk);
        chk("reset_rx_data", bus.rx_data, 0);
        chk("reset_rda", bus.rda, 0);
        chk("reset_frame_err", bus.frame_err, 0);
        chk("reset_overrun", bus.overrun, 0);
        rst = 1'b1;
        idle(20);

        // Tick every clk: start edge to rda is 2 sync + 152 ticks + 1 register edge.
        div = 1;
        idle(4);
        n = 0;
        fork
            send_frame(8'hC3, 1'b1);
            begin
                while (!bus.rda && n < 400) begin
                    @(negedge clk);
                    n++;
                end
            end
        join
        chk("latency_clks", n, 155);
        chk("latency_data", bus.rx_data, 8'hC3);
        pulse_rd();
        idle(10);

        div = 41;
        idle(100);
        send_frame(8'hA5, 1'b1);
        idle(41 * 8);
        chk("t1_rda", bus.rda, 1);
        chk("t1_data", bus.rx_data, 8'hA5);
        chk("t1_fe", bus.frame_err, 0);
        chk("t1_ov", bus.overrun, 0);
        pulse_rd();
        chk("t1_rda_cleared", bus.rda, 0);

        div = 4;
        idle(40);
        d0 = m_done;
        rxd = 1'b0;
        repeat (3 * 4) @(negedge clk);
        idle(16 * 4 * 2);
        chk("t2_glitch_rda", bus.rda, 0);
        chk("t2_glitch_no_done", m_done - d0, 0);
        send_frame(8'h3C, 1'b1);
        idle(40);
        chk("t2_data", bus.rx_data, 8'h3C);
        chk("t2_rda", bus.rda, 1);
        pulse_rd();
        idle(10);

        d0 = m_done;
        send_frame(8'h3C, 1'b0);
        rxd = 1'b0;
        repeat (30 * 16 * 4) @(negedge clk);
        chk("t3_one_done", m_done - d0, 1);
        chk("t3_rda", bus.rda, 1);
        chk("t3_data", bus.rx_data, 8'h3C);
        chk("t3_fe", bus.frame_err, 1);
        idle(100);
        send_frame(8'h96, 1'b1);
        idle(40);
        chk("t3_after_done", m_done - d0, 2);
        chk("t3_after_data", bus.rx_data, 8'h96);
        chk("t3_after_fe", bus.frame_err, 0);
        chk("t3_after_ov", bus.overrun, 1);
        pulse_rd();
        idle(10);

        send_frame(8'h11, 1'b1);
        idle(20);
        send_frame(8'h22, 1'b1);
        idle(40);
        chk("t4_data", bus.rx_data, 8'h22);
        chk("t4_rda", bus.rda, 1);
        chk("t4_ov", bus.overrun, 1);
        pulse_rd();
        chk("t4_clr_rda", bus.rda, 0);
        chk("t4_clr_ov", bus.overrun, 0);
        chk("t4_clr_fe", bus.frame_err, 0);

        div = 1;
        idle(40);
        send_frame(8'h44, 1'b1);
        idle(20);
        found = 1'b0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                for (int i = 0; i < 400 && !found; i++) begin
                    @(negedge clk);
                    if (m_busy && m_ofs == 151) found = 1'b1;
                end
                if (found) begin
                    rd_data = 1'b1;
                    @(negedge clk);
                    rd_data = 1'b0;
                end
            end
        join
        idle(20);
        chk("t5_sync_found", found, 1);
        chk("t5_rda", bus.rda, 1);
        chk("t5_data", bus.rx_data, 8'h55);
        chk("t5_ov", bus.overrun, 0);

        div = 4;
        idle(40);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rxd = 1'b1;
        repeat (8 * 4) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_rst_data", bus.rx_data, 0);
        chk("t6_rst_rda", bus.rda, 0);
        chk("t6_rst_fe", bus.frame_err, 0);
        chk("t6_rst_ov", bus.overrun, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        idle(20);
        send_frame(8'h80, 1'b1);
        idle(40);
        chk("t6_data", bus.rx_data, 8'h80);
        chk("t6_rda", bus.rda, 1);
        pulse_rd();

        rnd_rd = 1'b1;
        for (int f = 0; f < 24; f++) begin
            div = $urandom_range(1, 5);
            rb = 8'($urandom);
            st = ($urandom_range(0, 5) != 0);
            send_frame(rb, st);
            if (!st) begin
                rxd = 1'b0;
                repeat ($urandom_range(0, 3) * 16 * div) @(negedge clk);
            end
            idle($urandom_range(1, 32 * div));
        end
        rnd_rd = 1'b0;
        @(negedge clk);
        rd_data = 1'b0;
        idle(50);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
